div_result_bcd: RTL and testbench
=================================

// Module: div_result_bcd
// PURPOSE
//  Downstream stage of divisor_restoring_7bits. Captures quotient Q and remainder R on each new done,
//  converts both to packed BCD with a sequential double-dabble (shift-add-3) engine, and presents
//  stable decimal digits plus a one-cycle strobe to the display driver.
//  The two conversions run in parallel, one bit per clock.
// PARAMETERS
//  WIDTH   7  binary width of Q/R; must match the divider
//  DIGITS  3  BCD digits per value; 10**DIGITS > 2**WIDTH-1 is required (elaboration error otherwise)
// PORTS
//  clk        in   1           single clock, all state updates on posedge
//  rst        in   1           synchronous, active-low reset
//  done       in   1           divider done (level; may stay high many cycles)
//  Q          in   WIDTH       divider quotient, valid while done=1
//  R          in   WIDTH       divider remainder, valid while done=1
//  q_bcd      out  4*DIGITS    packed BCD of Q, hundreds in MSB nibble
//  r_bcd      out  4*DIGITS    packed BCD of R
//  bcd_valid  out  1           1-cycle strobe: q_bcd/r_bcd just updated
//  busy       out  1           1 while a conversion is in progress
// BEHAVIOUR
//  - Reset (rst=0 at posedge): state=IDLE, q_bcd=r_bcd=0, bcd_valid=0, busy=0, done_d=0, counter=0.
//  - Trigger: done_d registers done every cycle; start = done & ~done_d (rising edge only).
//    A level-held done therefore yields exactly one conversion.
//  - FSM: IDLE -> SHIFT -> UPDATE -> IDLE.
//    IDLE: on start, load Q and R into binary shift regs, clear BCD scratch, cnt=0, go SHIFT.
//    SHIFT: per cycle, per value: each scratch nibble >=5 gets +3, then {scratch,bin} <<= 1.
//      cnt increments; after WIDTH shifts (cnt==WIDTH-1 on that edge) go UPDATE.
//    UPDATE: copy scratch to q_bcd/r_bcd, bcd_valid=1 for this one cycle, go IDLE.
//  - busy=1 in SHIFT and UPDATE; 0 in IDLE.
//  - Latency: start sampled at edge k -> outputs and bcd_valid visible after edge k+WIDTH+1 (8 for WIDTH=7).
//  - Outputs hold their last value between conversions; never partially updated.
//  - Rising edge of done while busy=1: ignored (not queued). done_d still tracks it, so no
//    retrigger occurs when busy falls.
//  - Rising edge of done in the same cycle as UPDATE: ignored. It is accepted only in IDLE.
//  - Reset during SHIFT/UPDATE: abort, all outputs return to reset values, no bcd_valid strobe.
//  - Adjust compare/add is per 4-bit nibble, with no carry between nibbles. The scratch register is
//    4*DIGITS bits; with the parameter constraint, overflow cannot occur.
//  - Q=0 or R=0 converts to all-zero BCD. Divide-by-zero content is passed through as given.
// CONFIGURATION
//  BCD_BLANK_EN defined: adds outputs q_blank, r_blank [DIGITS-1:0], registered with q_bcd/r_bcd
//    in UPDATE.
//    bit i=1 when digit i and every higher digit are zero, i.e. leading-zero mask for the display.
//    Bit 0 (units) is always 0.
//    Both masks reset to 0.
//  BCD_BLANK_EN undefined: q_blank/r_blank ports and logic absent; all else identical.
// TESTING
//  1 rst=0 for 2 clks, release -> q_bcd=r_bcd=0, bcd_valid=0, busy=0.
//  2 Q=3,R=1, done rises -> bcd_valid exactly 8 clks later; q_bcd=12'h003, r_bcd=12'h001.
//  3 Q=127,R=0 -> q_bcd=12'h127, r_bcd=12'h000. Q=9,R=10 -> q_bcd=12'h009, r_bcd=12'h010.
//  4 done held high 30 clks -> exactly one bcd_valid pulse.
//    A second done rise at busy=1 -> no extra pulse, outputs unchanged.
//  5 Q=19,R=4: pulse rst=0 at cycle 4 of SHIFT -> outputs 0, no bcd_valid.
//    Next done rise -> 12'h019/12'h004.
//  6 BCD_BLANK_EN: Q=5,R=42 -> q_blank=3'b110, r_blank=3'b100. Q=100 -> q_blank=3'b000.

Source files
------------

// File: rtl/div_result_bcd.sv
// Converts the divider's quotient and remainder to packed BCD with two parallel
// shift-add-3 engines, one bit per clock. Define BCD_BLANK_EN for leading-zero masks.
module div_result_bcd #(
   parameter int WIDTH  = 7,
   parameter int DIGITS = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                done,
   input  logic [WIDTH-1:0]    Q,
   input  logic [WIDTH-1:0]    R,
   output logic [4*DIGITS-1:0] q_bcd,
   output logic [4*DIGITS-1:0] r_bcd,
   output logic                bcd_valid,
`ifdef BCD_BLANK_EN
   output logic [DIGITS-1:0]   q_blank,
   output logic [DIGITS-1:0]   r_blank,
`endif
   output logic                busy
);

   localparam int BW = 4 * DIGITS;
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   if (10 ** DIGITS <= 2 ** WIDTH - 1) begin : g_digits_too_few
      $error("div_result_bcd: DIGITS too small to hold 2**WIDTH-1");
   end

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_UPDATE
   } state_t;

   // Adjust every nibble >= 5 by +3 (no inter-nibble carry), then shift one binary bit in.
   function automatic logic [BW-1:0] dabble_step(input logic [BW-1:0] scr, input logic bit_in);
      logic [BW-1:0] adj;
      adj = scr;
      for (int i = 0; i < DIGITS; i++) begin
         if (scr[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scr[4*i +: 4] + 4'd3;
      end
      return {adj[BW-2:0], bit_in};
   endfunction

`ifdef BCD_BLANK_EN
   function automatic logic [DIGITS-1:0] leading_zero_mask(input logic [BW-1:0] bcd);
      logic [DIGITS-1:0] m;
      logic              all_zero;
      m        = '0;
      all_zero = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         all_zero = all_zero & (bcd[4*i +: 4] == 4'd0);
         m[i]     = all_zero;
      end
      m[0] = 1'b0;
      return m;
   endfunction
`endif

   state_t            state_q, state_d;
   logic              done_d_q;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [WIDTH-1:0]  q_bin_q, q_bin_d, r_bin_q, r_bin_d;
   logic [BW-1:0]     q_scr_q, q_scr_d, r_scr_q, r_scr_d;
   logic [BW-1:0]     q_bcd_q, q_bcd_d, r_bcd_q, r_bcd_d;
   logic              bcd_valid_q, bcd_valid_d;
   logic              start;
`ifdef BCD_BLANK_EN
   logic [DIGITS-1:0] q_blank_q, q_blank_d, r_blank_q, r_blank_d;
`endif

   assign start = done & ~done_d_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      q_bin_d     = q_bin_q;
      r_bin_d     = r_bin_q;
      q_scr_d     = q_scr_q;
      r_scr_d     = r_scr_q;
      q_bcd_d     = q_bcd_q;
      r_bcd_d     = r_bcd_q;
      bcd_valid_d = 1'b0;
`ifdef BCD_BLANK_EN
      q_blank_d   = q_blank_q;
      r_blank_d   = r_blank_q;
`endif
      case (state_q)
         ST_IDLE: begin
            // Edges of done arriving in SHIFT/UPDATE are dropped, never queued.
            if (start) begin
               q_bin_d = Q;
               r_bin_d = R;
               q_scr_d = '0;
               r_scr_d = '0;
               cnt_d   = '0;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            q_scr_d = dabble_step(q_scr_q, q_bin_q[WIDTH-1]);
            r_scr_d = dabble_step(r_scr_q, r_bin_q[WIDTH-1]);
            q_bin_d = {q_bin_q[WIDTH-2:0], 1'b0};
            r_bin_d = {r_bin_q[WIDTH-2:0], 1'b0};
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) state_d = ST_UPDATE;
         end
         ST_UPDATE: begin
            q_bcd_d     = q_scr_q;
            r_bcd_d     = r_scr_q;
            bcd_valid_d = 1'b1;
`ifdef BCD_BLANK_EN
            q_blank_d   = leading_zero_mask(q_scr_q);
            r_blank_d   = leading_zero_mask(r_scr_q);
`endif
            state_d     = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Control and visible outputs: cleared by reset, so an aborted conversion never strobes.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         done_d_q    <= 1'b0;
         cnt_q       <= '0;
         q_bcd_q     <= '0;
         r_bcd_q     <= '0;
         bcd_valid_q <= 1'b0;
`ifdef BCD_BLANK_EN
         q_blank_q   <= '0;
         r_blank_q   <= '0;
`endif
      end else begin
         state_q     <= state_d;
         done_d_q    <= done;
         cnt_q       <= cnt_d;
         q_bcd_q     <= q_bcd_d;
         r_bcd_q     <= r_bcd_d;
         bcd_valid_q <= bcd_valid_d;
`ifdef BCD_BLANK_EN
         q_blank_q   <= q_blank_d;
         r_blank_q   <= r_blank_d;
`endif
      end
   end

   // Working datapath: always reloaded in IDLE before use, so it carries no reset.
   always_ff @(posedge clk) begin
      q_bin_q <= q_bin_d;
      r_bin_q <= r_bin_d;
      q_scr_q <= q_scr_d;
      r_scr_q <= r_scr_d;
   end

   assign q_bcd     = q_bcd_q;
   assign r_bcd     = r_bcd_q;
   assign bcd_valid = bcd_valid_q;
   assign busy      = (state_q != ST_IDLE);
`ifdef BCD_BLANK_EN
   assign q_blank   = q_blank_q;
   assign r_blank   = r_blank_q;
`endif

endmodule

// File: tb/tb_div_result_bcd.sv
// Scoreboard bench for div_result_bcd: stimulus pushes hand-computed BCD results,
// a negedge monitor pops and compares them whenever bcd_valid strobes.
module tb_div_result_bcd;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        done = 1'b0;
   logic [6:0]  Q = '0;
   logic [6:0]  R = '0;
   logic [11:0] q_bcd, r_bcd;
   logic        bcd_valid, busy;
`ifdef BCD_BLANK_EN
   logic [2:0]  q_blank, r_blank;
`endif

   div_result_bcd #(.WIDTH(7), .DIGITS(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .done      (done),
      .Q         (Q),
      .R         (R),
      .q_bcd     (q_bcd),
      .r_bcd     (r_bcd),
      .bcd_valid (bcd_valid),
`ifdef BCD_BLANK_EN
      .q_blank   (q_blank),
      .r_blank   (r_blank),
`endif
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [11:0] q;
      logic [11:0] r;
      logic [2:0]  qb;
      logic [2:0]  rb;
      int          due;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [11:0] act, input logic [11:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // Monitor: every strobe must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst && bcd_valid) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_strobe: got q_bcd=%h r_bcd=%h, expected no strobe", q_bcd, r_bcd);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("q_bcd", q_bcd, e.q);
            chk("r_bcd", r_bcd, e.r);
            checks++;
            if (cyc != e.due) begin
               errors++;
               $display("FAIL latency: strobe at cycle %0d, expected cycle %0d", cyc, e.due);
            end
`ifdef BCD_BLANK_EN
            chk("q_blank", 12'(q_blank), 12'(e.qb));
            chk("r_blank", 12'(r_blank), 12'(e.rb));
`endif
         end
      end
   end

   // Raise done for 'hold' cycles; the strobe is due 8 edges after the sampling edge.
   task automatic issue(input logic [6:0] q, input logic [6:0] r,
                        input logic [11:0] eq, input logic [11:0] er,
                        input logic [2:0] eqb, input logic [2:0] erb, input int hold);
      exp_t e;
      @(negedge clk);
      Q = q;
      R = r;
      done = 1'b1;
      e.q = eq; e.r = er; e.qb = eqb; e.rb = erb; e.due = cyc + 1 + 8;
      sb.push_back(e);
      repeat (hold) @(negedge clk);
      done = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while (sb.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL timeout: %0d results outstanding, expected 0", sb.size());
         sb.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_q_bcd", q_bcd, 12'h000);
      chk("rst_r_bcd", r_bcd, 12'h000);
      chk("rst_valid", 12'(bcd_valid), 12'h000);
      chk("rst_busy", 12'(busy), 12'h000);

      // Basic conversions
      issue(7'd3,   7'd1,  12'h003, 12'h001, 3'b110, 3'b110, 1);
      wait_drain(20);
      issue(7'd127, 7'd0,  12'h127, 12'h000, 3'b000, 3'b110, 2);
      wait_drain(20);
      issue(7'd9,   7'd10, 12'h009, 12'h010, 3'b110, 3'b100, 1);
      wait_drain(20);
      issue(7'd5,   7'd42, 12'h005, 12'h042, 3'b110, 3'b100, 1);
      wait_drain(20);
      issue(7'd100, 7'd7,  12'h100, 12'h007, 3'b000, 3'b110, 1);
      wait_drain(20);
      issue(7'd99,  7'd99, 12'h099, 12'h099, 3'b100, 3'b100, 1);
      wait_drain(20);
      issue(7'd64,  7'd127, 12'h064, 12'h127, 3'b100, 3'b000, 1);
      wait_drain(20);

      // Level-held done gives one conversion only
      issue(7'd50, 7'd6, 12'h050, 12'h006, 3'b100, 3'b110, 30);
      wait_drain(20);

      // A new rise while busy is dropped and does not retrigger later
      issue(7'd88, 7'd11, 12'h088, 12'h011, 3'b100, 3'b100, 2);
      @(negedge clk);
      chk("busy_mid", 12'(busy), 12'h001);
      Q = 7'd77;
      R = 7'd3;
      done = 1'b1;
      repeat (12) @(negedge clk);
      done = 1'b0;
      wait_drain(20);
      repeat (12) @(negedge clk);
      chk("hold_q_bcd", q_bcd, 12'h088);
      chk("hold_r_bcd", r_bcd, 12'h011);

      // Reset during SHIFT aborts without a strobe
      @(negedge clk);
      Q = 7'd19;
      R = 7'd4;
      done = 1'b1;
      repeat (4) @(negedge clk);
      chk("busy_shift", 12'(busy), 12'h001);
      rst = 1'b0;
      done = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      chk("abort_q_bcd", q_bcd, 12'h000);
      chk("abort_r_bcd", r_bcd, 12'h000);
      chk("abort_busy", 12'(busy), 12'h000);
      chk("abort_valid", 12'(bcd_valid), 12'h000);
      repeat (12) @(negedge clk);
      issue(7'd19, 7'd4, 12'h019, 12'h004, 3'b100, 3'b110, 1);
      wait_drain(20);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
